// File: rtl/gte_addsel_sequencer_pkg.sv
// rtl/gte_addsel_sequencer_pkg.sv - shared types, opcodes and add-source selects for the GTE add-path sequencer
package gte_addsel_sequencer_pkg;

    typedef struct packed {
        logic [3:0] sel;
        logic [1:0] id;
        logic       use_sf;
    } gte_sel_add_ctrl_t;

    localparam logic [5:0] OP_RTPS  = 6'h01;
    localparam logic [5:0] OP_DPCS  = 6'h10;
    localparam logic [5:0] OP_INTPL = 6'h11;
    localparam logic [5:0] OP_MVMVA = 6'h12;
    localparam logic [5:0] OP_NCDS  = 6'h13;
    localparam logic [5:0] OP_CDP   = 6'h14;
    localparam logic [5:0] OP_AVSZ3 = 6'h2D;

    localparam logic [3:0] SEL_TR      = 4'd0;
    localparam logic [3:0] SEL_BK      = 4'd1;
    localparam logic [3:0] SEL_FC      = 4'd2;
    localparam logic [3:0] SEL_ZERO    = 4'd3;
    localparam logic [3:0] SEL_RGB     = 4'd4;
    localparam logic [3:0] SEL_MAC     = 4'd5;
    localparam logic [3:0] SEL_OTZ     = 4'd6;
    localparam logic [3:0] SEL_IR      = 4'd7;
    localparam logic [3:0] SEL_PROJ    = 4'd8;
    localparam logic [3:0] SEL_SPECIAL = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam gte_sel_add_ctrl_t CTRL_IDLE = '{sel: SEL_ZERO, id: 2'd0, use_sf: 1'b0};

endpackage

// File: rtl/gte_addsel_sequencer_if.sv
// rtl/gte_addsel_sequencer_if.sv - command/control bundle between decoder, sequencer and add-path selector
interface gte_addsel_sequencer_if;
    import gte_addsel_sequencer_pkg::*;

    logic              i_start;
    logic [5:0]        i_op;
    logic              i_sf;
    logic [1:0]        i_cv;
    logic              i_stall;
    logic              i_abort;
    logic              o_ready;
    logic              o_valid;
    gte_sel_add_ctrl_t o_ctrl;
    logic              o_isMVMVA;
    logic              o_SF;
    logic [1:0]        o_cv;
    logic              o_done;
    logic              o_err;

    modport master (
        output i_start, i_op, i_sf, i_cv, i_stall, i_abort,
        input  o_ready, o_valid, o_ctrl, o_isMVMVA, o_SF, o_cv, o_done, o_err
    );

    modport slave (
        input  i_start, i_op, i_sf, i_cv, i_stall, i_abort,
        output o_ready, o_valid, o_ctrl, o_isMVMVA, o_SF, o_cv, o_done, o_err
    );

endinterface

// File: rtl/gte_addsel_sequencer_rom.sv
// rtl/gte_addsel_sequencer_rom.sv - opcode to add-source step table lookup
module gte_addsel_rom
    import gte_addsel_sequencer_pkg::*;
#(
    parameter int STEP_MAX = 3,
    parameter int STEP_W   = 2
) (
    input  logic [5:0]                op,
    output logic [STEP_W-1:0]         nsteps,
    output logic [STEP_MAX-1:0][3:0]  sel,
    output logic [STEP_MAX-1:0]       use_sf,
    output logic                      supported,
    output logic                      is_mvmva
);

    // step table; the MAC source is the only one that scales by SF
    always_comb begin
        nsteps    = '0;
        sel       = {STEP_MAX{SEL_ZERO}};
        supported = 1'b1;
        is_mvmva  = 1'b0;
        case (op)
            OP_RTPS:  begin nsteps = STEP_W'(2); sel[0] = SEL_TR;  sel[1] = SEL_PROJ;    end
            OP_DPCS:  begin nsteps = STEP_W'(2); sel[0] = SEL_RGB; sel[1] = SEL_FC;      end
            OP_INTPL: begin nsteps = STEP_W'(2); sel[0] = SEL_IR;  sel[1] = SEL_FC;      end
            OP_MVMVA: begin nsteps = STEP_W'(1); sel[0] = SEL_TR;  is_mvmva = 1'b1;      end
            OP_NCDS:  begin nsteps = STEP_W'(2); sel[0] = SEL_BK;  sel[1] = SEL_SPECIAL; end
            OP_CDP:   begin nsteps = STEP_W'(2); sel[0] = SEL_BK;  sel[1] = SEL_FC;      end
            OP_AVSZ3: begin nsteps = STEP_W'(1); sel[0] = SEL_OTZ;                       end
            default:  supported = 1'b0;
        endcase
        use_sf = '0;
        for (int i = 0; i < STEP_MAX; i++) begin
            use_sf[i] = (sel[i] == SEL_MAC);
        end
    end

endmodule

// File: rtl/gte_addsel_sequencer.sv
// rtl/gte_addsel_sequencer.sv - GTE add-path microcode sequencer; optional perf counters under GTE_ADDSEQ_PERF_EN
module gte_addsel_sequencer
    import gte_addsel_sequencer_pkg::*;
#(
    parameter int STEP_MAX = 3,
    parameter int PERF_W   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_nRst,
    gte_addsel_sequencer_if.slave  bus,
    output logic [PERF_W-1:0]      o_perf_busy,
    output logic [PERF_W-1:0]      o_perf_stall
);

    localparam int STEP_W = $clog2(STEP_MAX + 1);

    seq_state_t              state_q, state_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [1:0]              id_q, id_d;
    logic [5:0]              op_q, op_d;
    logic                    sf_q, sf_d;
    logic [1:0]              cv_q, cv_d;
    logic                    err_q, err_d;

    logic [5:0]              rom_op;
    logic [STEP_W-1:0]       rom_nsteps;
    logic [STEP_MAX-1:0][3:0] rom_sel;
    logic [STEP_MAX-1:0]     rom_use_sf;
    logic                    rom_supported;
    logic                    rom_is_mvmva;
    logic                    accept;

    // in IDLE the table is consulted with the incoming opcode to decide RUN vs error
    assign rom_op = (state_q == ST_IDLE) ? bus.i_op : op_q;
    assign accept = (state_q == ST_IDLE) && bus.i_start && !bus.i_abort;

    gte_addsel_rom #(
        .STEP_MAX (STEP_MAX),
        .STEP_W   (STEP_W)
    ) u_rom (
        .op        (rom_op),
        .nsteps    (rom_nsteps),
        .sel       (rom_sel),
        .use_sf    (rom_use_sf),
        .supported (rom_supported),
        .is_mvmva  (rom_is_mvmva)
    );

    // sequencer state register
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            id_q    <= '0;
            op_q    <= '0;
            sf_q    <= 1'b0;
            cv_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            id_q    <= id_d;
            op_q    <= op_d;
            sf_q    <= sf_d;
            cv_q    <= cv_d;
            err_q   <= err_d;
        end
    end

    // next-state and control outputs; abort dominates everything, stall freezes RUN
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        id_d          = id_q;
        op_d          = op_q;
        sf_d          = sf_q;
        cv_d          = cv_q;
        err_d         = err_q;
        bus.o_ready   = (state_q == ST_IDLE) && !bus.i_abort;
        bus.o_valid   = 1'b0;
        bus.o_ctrl    = CTRL_IDLE;
        bus.o_isMVMVA = 1'b0;
        bus.o_SF      = sf_q;
        bus.o_cv      = cv_q;
        bus.o_done    = 1'b0;
        bus.o_err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = bus.i_op;
                    sf_d    = bus.i_sf;
                    cv_d    = bus.i_cv;
                    step_d  = '0;
                    id_d    = '0;
                    err_d   = !rom_supported;
                    state_d = rom_supported ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                bus.o_valid   = 1'b1;
                bus.o_ctrl    = '{sel: rom_sel[step_q], id: id_q, use_sf: rom_use_sf[step_q]};
                bus.o_isMVMVA = rom_is_mvmva;
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    id_d    = '0;
                    err_d   = 1'b0;
                end else if (!bus.i_stall) begin
                    if (id_q == 2'd2) begin
                        id_d = '0;
                        if (step_q == rom_nsteps - STEP_W'(1)) begin
                            state_d = ST_DONE;
                            step_d  = '0;
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end else begin
                        id_d = id_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                bus.o_done = 1'b1;
                bus.o_err  = err_q;
                state_d    = ST_IDLE;
                err_d      = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef GTE_ADDSEQ_PERF_EN
    logic [PERF_W-1:0] busy_q, stall_q;

    // saturating RUN / stalled-RUN cycle counters, restarted by each accepted command
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else if (accept) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else if (state_q == ST_RUN) begin
            if (busy_q != '1) begin
                busy_q <= busy_q + PERF_W'(1);
            end
            if (bus.i_stall && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_W'(1);
            end
        end
    end

    assign o_perf_busy  = busy_q;
    assign o_perf_stall = stall_q;
`else
    assign o_perf_busy  = '0;
    assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_gte_addsel_sequencer.sv
// tb/tb_gte_addsel_sequencer.sv - self-checking bench for gte_addsel_sequencer
module tb_gte_addsel_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] perf_busy;
    logic [15:0] perf_stall;
    int          total;
    int          bad;
    int          exp_sel[$];
    bit          exp_ok;

    gte_addsel_sequencer_if bus ();

    gte_addsel_sequencer #(
        .STEP_MAX (3),
        .PERF_W   (16)
    ) dut (
        .i_clk        (clk),
        .i_nRst       (rst_n),
        .bus          (bus),
        .o_perf_busy  (perf_busy),
        .o_perf_stall (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic model_table(input logic [5:0] op);
        exp_sel.delete();
        exp_ok = 1'b1;
        case (op)
            6'h01:   exp_sel = {0, 8};
            6'h10:   exp_sel = {4, 2};
            6'h11:   exp_sel = {7, 2};
            6'h12:   exp_sel = {0};
            6'h13:   exp_sel = {1, 9};
            6'h14:   exp_sel = {1, 2};
            6'h2D:   exp_sel = {6};
            default: exp_ok = 1'b0;
        endcase
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [5:0] op, input logic sf, input logic [1:0] cv,
                           input int stall_at, input int stall_n, input bit rnd, output int lat);
        int         idx;
        int         nent;
        int         left;
        int         nst;
        bit         st;
        logic [3:0] es;
        logic [15:0] eb;
        logic [15:0] es_cnt;
        model_table(op);
        nent = exp_sel.size() * 3;
        left = stall_n;
        nst  = 0;
        idx  = 0;
        lat  = 0;
        @(negedge clk);
        total++;
        if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL ready_before_start: got %b expected 1", bus.o_ready); end
        bus.i_start = 1'b1; bus.i_op = op; bus.i_sf = sf; bus.i_cv = cv;
        bus.i_stall = 1'b0; bus.i_abort = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            bus.i_stall = 1'b0;
            if (idx < nent) begin
                es = exp_sel[idx / 3][3:0];
                total++;
                if (bus.o_valid !== 1'b1 || bus.o_ctrl.sel !== es || bus.o_ctrl.id !== 2'(idx % 3)
                    || bus.o_ctrl.use_sf !== 1'b0) begin
                    bad++;
                    $display("FAIL step op=%h idx=%0d: got valid=%b sel=%0d id=%0d sf=%b expected 1 %0d %0d 0",
                             op, idx, bus.o_valid, bus.o_ctrl.sel, bus.o_ctrl.id, bus.o_ctrl.use_sf, es, idx % 3);
                end
                check_bit("run_done_low", bus.o_done, 1'b0);
                check_bit("run_is_mvmva", bus.o_isMVMVA, op == 6'h12);
                check_bit("run_o_SF", bus.o_SF, sf);
                total++;
                if (bus.o_cv !== cv) begin bad++; $display("FAIL run_o_cv: got %0d expected %0d", bus.o_cv, cv); end
                // noise on the command inputs must not disturb a running command
                bus.i_start = 1'($urandom);
                bus.i_op    = 6'($urandom);
                bus.i_sf    = 1'($urandom);
                bus.i_cv    = 2'($urandom);
                st = 1'b0;
                if (rnd) st = ($urandom_range(0, 3) == 0);
                else if (idx == stall_at && left > 0) begin st = 1'b1; left--; end
                bus.i_stall = st;
                if (st) nst++;
                else idx++;
            end else begin
                check_bit("done_pulse", bus.o_done, 1'b1);
                check_bit("done_err", bus.o_err, !exp_ok);
                check_bit("done_valid_low", bus.o_valid, 1'b0);
                check_bit("done_is_mvmva_low", bus.o_isMVMVA, 1'b0);
                total++;
                if (bus.o_ctrl !== 7'b0011_00_0) begin bad++; $display("FAIL done_ctrl_zero: got %b expected 0011000", bus.o_ctrl); end
                bus.i_stall = 1'($urandom);
                lat = cyc;
                break;
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL timeout op=%h: no done within 100 cycles", op);
        end
        total++;
        if (lat != 3 * exp_sel.size() + 1 + nst) begin
            bad++;
            $display("FAIL latency op=%h: got %0d expected %0d", op, lat, 3 * exp_sel.size() + 1 + nst);
        end
`ifdef GTE_ADDSEQ_PERF_EN
        eb = 16'(lat - 1);
        es_cnt = 16'(nst);
`else
        eb = 16'd0;
        es_cnt = 16'd0;
`endif
        total++;
        if (perf_busy !== eb || perf_stall !== es_cnt) begin
            bad++;
            $display("FAIL perf op=%h: got busy=%0d stall=%0d expected %0d %0d", op, perf_busy, perf_stall, eb, es_cnt);
        end
        @(negedge clk);
        bus.i_stall = 1'b0;
        check_bit("after_done_ready", bus.o_ready, 1'b1);
        check_bit("after_done_no_done", bus.o_done, 1'b0);
        check_bit("after_done_valid", bus.o_valid, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        check_bit({tag, "_ready"}, bus.o_ready, 1'b1);
        check_bit({tag, "_valid"}, bus.o_valid, 1'b0);
        check_bit({tag, "_done"}, bus.o_done, 1'b0);
        check_bit({tag, "_err"}, bus.o_err, 1'b0);
        check_bit({tag, "_is_mvmva"}, bus.o_isMVMVA, 1'b0);
        total++;
        if (bus.o_ctrl !== 7'b0011_00_0) begin bad++; $display("FAIL %s_ctrl: got %b expected 0011000", tag, bus.o_ctrl); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_idle("reset");
        check_bit("reset_o_SF", bus.o_SF, 1'b0);
        total++;
        if (bus.o_cv !== 2'd0 || perf_busy !== 16'd0 || perf_stall !== 16'd0) begin
            bad++;
            $display("FAIL reset_regs: got cv=%0d busy=%0d stall=%0d expected 0 0 0", bus.o_cv, perf_busy, perf_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // async reset in the middle of a command
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_op = 6'h01; bus.i_sf = 1'b1; bus.i_cv = 2'd3;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        check_bit("mid_cmd_valid_before_reset", bus.o_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        check_bit("mid_reset_o_SF", bus.o_SF, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_bit("post_reset_no_done", bus.o_done, 1'b0);
            check_bit("post_reset_no_valid", bus.o_valid, 1'b0);
        end
    endtask

    task automatic test_rtps();
        int lat;
        run_cmd(6'h01, 1'b0, 2'd0, -1, 0, 1'b0, lat);
        total++;
        if (lat != 7) begin bad++; $display("FAIL rtps_latency: got %0d expected 7", lat); end
    endtask

    task automatic test_mvmva();
        int lat;
        run_cmd(6'h12, 1'b1, 2'd2, -1, 0, 1'b0, lat);
        total++;
        if (lat != 4) begin bad++; $display("FAIL mvmva_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_stall();
        int lat;
        run_cmd(6'h10, 1'b0, 2'd1, 1, 2, 1'b0, lat);
        total++;
        if (lat != 9) begin bad++; $display("FAIL dpcs_stall_latency: got %0d expected 9", lat); end
`ifdef GTE_ADDSEQ_PERF_EN
        total++;
        if (perf_busy !== 16'd8 || perf_stall !== 16'd2) begin
            bad++;
            $display("FAIL dpcs_perf: got busy=%0d stall=%0d expected 8 2", perf_busy, perf_stall);
        end
`else
        total++;
        if (perf_busy !== 16'd0 || perf_stall !== 16'd0) begin
            bad++;
            $display("FAIL dpcs_perf_off: got busy=%0d stall=%0d expected 0 0", perf_busy, perf_stall);
        end
`endif
    endtask

    task automatic test_unsupported();
        int lat;
        run_cmd(6'h3F, 1'b0, 2'd0, -1, 0, 1'b0, lat);
        total++;
        if (lat != 1) begin bad++; $display("FAIL unsupported_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_abort();
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_op = 6'h13; bus.i_sf = 1'b0; bus.i_cv = 2'd0;
        bus.i_stall = 1'b0; bus.i_abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        total++;
        if (bus.o_valid !== 1'b1 || bus.o_ctrl.sel !== 4'd9 || bus.o_ctrl.id !== 2'd0) begin
            bad++;
            $display("FAIL ncds_step1: got valid=%b sel=%0d id=%0d expected 1 9 0", bus.o_valid, bus.o_ctrl.sel, bus.o_ctrl.id);
        end
        bus.i_abort = 1'b1; bus.i_start = 1'b1; bus.i_op = 6'h01;
        @(negedge clk);
        bus.i_abort = 1'b0; bus.i_start = 1'b0;
        #1;
        check_idle("after_abort");
        // start and abort together in IDLE: start must be dropped
        bus.i_start = 1'b1; bus.i_abort = 1'b1; bus.i_op = 6'h01;
        #1;
        check_bit("abort_blocks_ready", bus.o_ready, 1'b0);
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_abort = 1'b0;
        #1;
        check_idle("start_with_abort");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_bit("abort_no_later_done", bus.o_done, 1'b0);
            check_bit("abort_no_later_valid", bus.o_valid, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[8];
        logic [5:0] op;
        int         lat;
        ops = '{6'h01, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h2D, 6'h00};
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'h00) op = 6'($urandom);
            run_cmd(op, 1'($urandom), 2'($urandom), -1, 0, 1'b1, lat);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_op = '0; bus.i_sf = 1'b0; bus.i_cv = '0;
        bus.i_stall = 1'b0; bus.i_abort = 1'b0;
        test_reset();
        test_rtps();
        test_mvmva();
        test_stall();
        test_unsupported();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gte_addsel_sequencer.md
Name: gte_addsel_sequencer

Overview:
Microcode sequencer that drives the control inputs of the GTE add-path selector: source select, component id and SF enable, plus the MVMVA/SF/CV side inputs.
- Accepts one GTE command at a time.
- Walks its add-source steps, emitting one component (id 0, 1, 2) per cycle.
- Honours a datapath stall and an abort.
- Signals completion.
- Sits between the GTE command decoder and the add-path selector inside the GTE core.

Parameters:
- STEP_MAX, 3, maximum add steps per command; sizes the step counter.
- PERF_W, 16, width of the performance counters; used only with the optional feature.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_nRst  in  1  reset; asynchronous assert, active-low.
- i_start  in  1  command request; accepted only when o_ready=1.
- i_op  in  6  GTE opcode (low 6 bits of the command).
- i_sf  in  1  command SF bit.
- i_cv  in  2  MVMVA translation-vector select.
- i_stall  in  1  datapath stall; freezes the sequence.
- i_abort  in  1  synchronous flush to IDLE.
- o_ready  out  1  idle; can accept i_start.
- o_valid  out  1  o_ctrl is a live step.
- o_ctrl  out  gteSelAddCtrl  {sel[3:0], id[1:0], useSF}.
- o_isMVMVA  out  1  registered: command is MVMVA.
- o_SF  out  1  registered copy of i_sf.
- o_cv  out  2  registered copy of i_cv.
- o_done  out  1  one-cycle pulse at end of command.
- o_err  out  1  one-cycle pulse, coincident with o_done, for an unsupported opcode.
- o_perf_busy  out  PERF_W  RUN cycle count; optional feature.
- o_perf_stall  out  PERF_W  stalled RUN cycle count; optional feature.

Behaviour:
Reset values (i_nRst low):
- State IDLE; o_ready=1.
- o_valid, o_done, o_err, o_isMVMVA, o_SF = 0; o_cv=0.
- o_ctrl={sel=3, id=0, useSF=0}, i.e. forced ZERO.
- Perf counters = 0.

States: IDLE, RUN, DONE.

IDLE:
- Accepting i_start (with i_abort=0) latches op, sf and cv.
- Step table is looked up (ROM). A supported op goes to RUN with step=0, id=0.
- An unsupported op goes straight to DONE with the error flag set.
- First o_valid is the cycle after acceptance.

Step table (sel per step; useSF=1 only where marked):
- RTPS 0x01: 0, 8.
- DPCS 0x10: 4, 2.
- INTPL 0x11: 7, 2.
- MVMVA 0x12: 0. o_isMVMVA=1, so the datapath substitutes cv; sel 3 is never emitted for MVMVA.
- NCDS 0x13: 1, 9.
- CDP 0x14: 1, 2.
- AVSZ3 0x2D: 6.
- Step 5 (MAC) carries useSF=1; it is not used by the base table and is reserved for future entries.
- Every other op is unsupported.

RUN:
- o_valid=1; o_ctrl.sel=table[step]; o_ctrl.id=id.
- Each cycle with i_stall=0: id advances 0→1→2; id 2 wraps to 0 and step increments.
- The last step at id=2 with no stall moves to DONE.
- i_stall=1: all outputs and counters hold.
- Latency from accept to o_done = 3·nsteps + 1 cycles, plus stall cycles.

DONE:
- One cycle: o_done=1, o_valid=0, o_err=error flag.
- Next state IDLE. Stall is ignored.

Common rules:
- Whenever o_valid=0, o_ctrl={3,0,0} and o_isMVMVA=0.
- o_ready = (state==IDLE) && !i_abort.
- i_start outside IDLE is ignored, not queued.
- i_abort in any state: next state IDLE, counters clear, no o_done/o_err pulse.
- i_abort and i_start in the same cycle: abort wins, the start is dropped.
- Async reset mid-command: immediate IDLE, no done pulse.

Optional Feature:
- Macro GTE_ADDSEQ_PERF_EN.
- Defined: o_perf_busy counts RUN cycles and o_perf_stall counts RUN cycles with i_stall=1. Both counters saturate at all-ones, clear on an accepted start and hold in IDLE and DONE.
- Undefined: both ports tie to 0 and no counter flops are built.

Decomposition:
- GTEDefine.hv (shared): gteSelAddCtrl typedef, opcode constants, SEL_* source constants (SEL_TR=0 … SEL_SPECIAL=9, SEL_ZERO=3), and the state enum.
- One sub-module, gte_addsel_rom: combinational op → {nsteps, sel[STEP_MAX], useSF[STEP_MAX], supported, isMVMVA}.

Test Plan:
1. Reset then RTPS (0x01), no stall → o_valid for 6 cycles: sel 0,0,0,8,8,8 with id 0,1,2,0,1,2; o_done on cycle 7; o_ready on cycle 8.
2. MVMVA, i_cv=2, i_sf=1 → 3 valid cycles with sel=0, o_isMVMVA=1, o_cv=2, o_SF=1; done on cycle 4.
3. DPCS with i_stall high for 2 cycles at step 0, id 1 → sel=4/id=1 held 3 cycles; total accept-to-done latency 9 cycles.
4. Opcode 0x3F → no o_valid; o_done=o_err=1 on the cycle after accept.
5. i_abort during NCDS step 1 → o_valid low next cycle, no o_done, o_ready=1; a same-cycle start with abort is ignored.
6. With GTE_ADDSEQ_PERF_EN: test 3 gives o_perf_busy=8 and o_perf_stall=2. Without the macro, both read 0.
